// File: rtl/my_fifo_pkg.sv
// Shared defaults and derived widths for the my_fifo block.
package my_fifo_pkg;

  // Default word width and depth (depth must be a power of two, >= 2).
  localparam int FIFO_DATA_WIDTH = 4;
  localparam int FIFO_DEPTH      = 8;

  // Address width needed to index a storage array of the given depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int ADDR_W = addr_width(FIFO_DEPTH);

endpackage : my_fifo_pkg

// File: rtl/my_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: clocked write port, combinational read port.
module my_fifo_mem
  import my_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is never reset; only words behind the read pointer are ever observed.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address when a write is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read so the top can register the word on the accepting edge.
  assign rd_data = mem_q[rd_addr];

endmodule : my_fifo_mem

// File: rtl/my_fifo.sv
// Synchronous FIFO: wrap-bit pointers, registered read data, decoded flags.
module my_fifo
  import my_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags decode registered pointers only, so inputs never reach them combinationally.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Requests qualify against pre-edge flags; reset blocks storage writes too.
  assign wr_accept = write_en && !full && reset;
  assign rd_accept = read_en && !empty;

  my_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_data(data_in),
    .rd_addr(rd_ptr_q[AW-1:0]),
    .rd_data(mem_rdata)
  );

  // Next-state for pointers and output register; everything holds by default.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_rdata;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule : my_fifo

// File: tb/tb_my_fifo.sv
// Directed, table-driven bench for my_fifo (DATA_WIDTH=4, DEPTH=8).
module tb_my_fifo;

  logic       clk;
  logic       reset;
  logic       read_en;
  logic       write_en;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       full;
  logic       empty;

  int checks;
  int failures;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] din;
    logic [3:0] dout;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  my_fifo #(
    .DATA_WIDTH(4),
    .DEPTH     (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .read_en (read_en),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [3:0] din,
                     input logic [3:0] dout, input logic e, input logic f);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.empty = e; v.full = f;
    vecs.push_back(v);
  endtask

  // One clock edge with the given requests; outputs sampled 1 time unit after the edge.
  task automatic step(input logic wr, input logic rd, input logic [3:0] din);
    @(negedge clk);
    write_en = wr;
    read_en  = rd;
    data_in  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    read_en  = 1'b0;
    write_en = 1'b0;
    data_in  = 4'd0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_dout", data_out, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic order: write 5,7,11 then three reads.
    add(1, 0, 4'd5,  4'd0,  0, 0);
    add(1, 0, 4'd7,  4'd0,  0, 0);
    add(1, 0, 4'd11, 4'd0,  0, 0);
    add(0, 1, 4'd0,  4'd5,  0, 0);
    add(0, 1, 4'd0,  4'd7,  0, 0);
    add(0, 1, 4'd0,  4'd11, 1, 0);
    // Fill with 0..7, rejected write of 15, drain in order.
    for (int i = 0; i < 8; i++) add(1, 0, 4'(i), 4'd11, 0, (i == 7));
    add(1, 0, 4'd15, 4'd11, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 4'd0, 4'(i), (i == 7), 0);
    // Read while empty holds data_out.
    add(0, 1, 4'd0, 4'd7, 1, 0);
    // Three held, then four simultaneous read+write edges across the wrap.
    add(1, 0, 4'd1, 4'd7, 0, 0);
    add(1, 0, 4'd2, 4'd7, 0, 0);
    add(1, 0, 4'd3, 4'd7, 0, 0);
    add(1, 1, 4'd4, 4'd1, 0, 0);
    add(1, 1, 4'd5, 4'd2, 0, 0);
    add(1, 1, 4'd6, 4'd3, 0, 0);
    add(1, 1, 4'd7, 4'd4, 0, 0);
    add(0, 1, 4'd0, 4'd5, 0, 0);
    add(0, 1, 4'd0, 4'd6, 0, 0);
    add(0, 1, 4'd0, 4'd7, 1, 0);
    // Simultaneous on empty: only the write happens, data_out holds.
    add(1, 1, 4'd9, 4'd7, 0, 0);
    // Fill to full, then simultaneous on full: only the read happens.
    add(1, 0, 4'd10, 4'd7, 0, 0);
    add(1, 0, 4'd11, 4'd7, 0, 0);
    add(1, 0, 4'd12, 4'd7, 0, 0);
    add(1, 0, 4'd13, 4'd7, 0, 0);
    add(1, 0, 4'd14, 4'd7, 0, 0);
    add(1, 0, 4'd15, 4'd7, 0, 0);
    add(1, 0, 4'd0,  4'd7, 0, 1);
    add(1, 1, 4'd5,  4'd9, 0, 0);
    add(0, 1, 4'd0, 4'd10, 0, 0);
    add(0, 1, 4'd0, 4'd11, 0, 0);
    add(0, 1, 4'd0, 4'd12, 0, 0);
    add(0, 1, 4'd0, 4'd13, 0, 0);
    add(0, 1, 4'd0, 4'd14, 0, 0);
    add(0, 1, 4'd0, 4'd15, 0, 0);
    add(0, 1, 4'd0, 4'd0,  1, 0);
    add(0, 1, 4'd0, 4'd0,  1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      $display("vec %0d wr=%0d rd=%0d din=%0d -> dout=%0d empty=%0d full=%0d (exp %0d/%0d/%0d)",
               i, vecs[i].wr, vecs[i].rd, vecs[i].din, data_out, empty, full,
               vecs[i].dout, vecs[i].empty, vecs[i].full);
      check($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("vec%0d_full", i), full, vecs[i].full);
    end

    // Mid-burst asynchronous reset: five writes, one read leaves 4 held with data_out=1.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 4'(i));
    step(1'b0, 1'b1, 4'd0);
    $display("pre-reset dout=%0d empty=%0d full=%0d", data_out, empty, full);
    check("prereset_dout", data_out, 1);
    check("prereset_empty", empty, 0);
    @(negedge clk);
    write_en = 1'b1;
    read_en  = 1'b0;
    data_in  = 4'd6;
    #2 reset = 1'b0;
    #1;
    $display("async reset dout=%0d empty=%0d full=%0d", data_out, empty, full);
    check("areset_dout", data_out, 0);
    check("areset_empty", empty, 1);
    check("areset_full", full, 0);
    // Requests held across an edge while in reset are ignored.
    read_en = 1'b1;
    @(posedge clk);
    #1;
    $display("in reset dout=%0d empty=%0d full=%0d", data_out, empty, full);
    check("inreset_empty", empty, 1);
    check("inreset_dout", data_out, 0);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    $display("read after release dout=%0d empty=%0d", data_out, empty);
    check("postreset_read_dout", data_out, 0);
    check("postreset_read_empty", empty, 1);
    step(1'b1, 1'b0, 4'd9);
    check("resume_write_empty", empty, 0);
    step(1'b0, 1'b1, 4'd0);
    $display("resume read dout=%0d empty=%0d", data_out, empty);
    check("resume_read_dout", data_out, 9);
    check("resume_read_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_my_fifo
